// File: rtl/whackamole_pkg.sv
// Shared definitions for the whack-a-mole game blocks.
package whackamole_pkg;

    localparam int unsigned CLK_HZ               = 100_000_000;
    localparam int unsigned DEFAULT_GAME_SECONDS = 30;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with synchronous load, decrement enable and
// ones-to-tens borrow. Holds at 00 rather than wrapping.
module bcd_down_counter #(
    parameter logic [3:0] RESET_TENS = 4'd0,
    parameter logic [3:0] RESET_ONES = 4'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       dec,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic borrow_c;
    logic zero_c;

    // Ones digit at 0 means the next decrement borrows from tens.
    assign borrow_c = (ones == 4'd0);
    assign zero_c   = borrow_c && (tens == 4'd0);

    // Digit registers: load has priority over decrement.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tens <= RESET_TENS;
            ones <= RESET_ONES;
        end else if (load) begin
            tens <= load_tens;
            ones <= load_ones;
        end else if (dec && !zero_c) begin
            if (borrow_c) begin
                ones <= 4'd9;
                tens <= tens - 4'd1;
            end else begin
                ones <= ones - 4'd1;
            end
        end
    end

endmodule

// File: rtl/game_timer.sv
// Round countdown timer: self-generated 1 s tick, binary and BCD remaining
// time, warning level, expiry level and one-cycle expiry strobe.
module game_timer
    import whackamole_pkg::*;
#(
    parameter int unsigned CLKS_PER_SEC = CLK_HZ,
    parameter int unsigned GAME_SECONDS = DEFAULT_GAME_SECONDS,
    parameter int unsigned WARN_SECONDS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    output logic       running,
    output logic [6:0] time_left,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       warning,
    output logic       timer_expired,
    output logic       expired_pulse
);

    localparam int unsigned PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam int unsigned TW = 7;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_SEC - 1);
    localparam logic [TW-1:0] GAME_LOAD = TW'(GAME_SECONDS);
    localparam logic [TW-1:0] WARN_LVL  = TW'(WARN_SECONDS);
    localparam logic [3:0]    INIT_TENS = 4'(GAME_SECONDS / 10);
    localparam logic [3:0]    INIT_ONES = 4'(GAME_SECONDS % 10);

    state_t         state, state_d;
    logic [PW-1:0]  presc, presc_d;
    logic [TW-1:0]  time_d;
    logic           load_c;
    logic           tick_c;

    // State, prescaler and registered outputs; outputs follow the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            presc         <= '0;
            time_left     <= GAME_LOAD;
            running       <= 1'b0;
            warning       <= 1'b0;
            timer_expired <= 1'b0;
            expired_pulse <= 1'b0;
        end else begin
            state         <= state_d;
            presc         <= presc_d;
            time_left     <= time_d;
            running       <= (state_d == RUNNING);
            warning       <= (state_d == RUNNING) && (time_d <= WARN_LVL);
            timer_expired <= (state_d == EXPIRED);
            expired_pulse <= (state == RUNNING) && (state_d == EXPIRED);
        end
    end

    // Next-state, prescaler and countdown; a final tick beats a coincident start.
    always_comb begin
        state_d = state;
        presc_d = presc;
        time_d  = time_left;
        load_c  = 1'b0;
        tick_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = RUNNING;
                    load_c  = 1'b1;
                end
            end
            RUNNING: begin
                if (!pause) begin
                    if (presc == PRESC_MAX) begin
                        tick_c  = 1'b1;
                        presc_d = '0;
                        time_d  = time_left - TW'(1);
                        if (time_left == TW'(1)) begin
                            state_d = EXPIRED;
                        end
                    end else begin
                        presc_d = presc + PW'(1);
                    end
                end
            end
            EXPIRED: begin
                if (start) begin
                    state_d = RUNNING;
                    load_c  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load_c) begin
            presc_d = '0;
            time_d  = GAME_LOAD;
        end
    end

    // BCD mirror of time_left, stepped by the same load and tick.
    bcd_down_counter #(
        .RESET_TENS(INIT_TENS),
        .RESET_ONES(INIT_ONES)
    ) u_bcd (
        .clock     (clock),
        .reset     (reset),
        .load      (load_c),
        .load_tens (INIT_TENS),
        .load_ones (INIT_ONES),
        .dec       (tick_c),
        .tens      (bcd_tens),
        .ones      (bcd_ones)
    );

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench: expected output snapshots are queued by cycle number and
// a negedge monitor pops and compares them against two timer instances.
module tb_game_timer;

    logic clock;
    logic reset;
    logic start_a, pause_a, start_b, pause_b;

    logic       running_a, warning_a, expired_a, pulse_a;
    logic [6:0] tl_a;
    logic [3:0] tens_a, ones_a;
    logic       running_b, warning_b, expired_b, pulse_b;
    logic [6:0] tl_b;
    logic [3:0] tens_b, ones_b;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int          c;
        int          inst;
        logic [18:0] snap;
    } exp_t;

    exp_t sb[$];

    // Instance A: short round, warning at 1 s.
    game_timer #(.CLKS_PER_SEC(4), .GAME_SECONDS(3), .WARN_SECONDS(1)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .pause(pause_a),
        .running(running_a), .time_left(tl_a), .bcd_tens(tens_a), .bcd_ones(ones_a),
        .warning(warning_a), .timer_expired(expired_a), .expired_pulse(pulse_a)
    );

    // Instance B: BCD borrow and warning threshold.
    game_timer #(.CLKS_PER_SEC(4), .GAME_SECONDS(12), .WARN_SECONDS(10)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .pause(pause_b),
        .running(running_b), .time_left(tl_b), .bcd_tens(tens_b), .bcd_ones(ones_b),
        .warning(warning_b), .timer_expired(expired_b), .expired_pulse(pulse_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Queue one expected snapshot; digits derived by decimal split.
    task automatic expect_at(input int c, input int inst, input logic run, input int tl,
                             input logic warn, input logic expd, input logic pulse);
        exp_t e;
        e.c    = c;
        e.inst = inst;
        e.snap = {run, 7'(tl), 4'(tl / 10), 4'(tl % 10), warn, expd, pulse};
        sb.push_back(e);
    endtask

    task automatic at_neg(input int k);
        while (cyc < k) @(negedge clock);
    endtask

    // Monitor: compare every snapshot whose cycle has come.
    always @(negedge clock) begin
        logic [18:0] act;
        exp_t e;
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            e = sb.pop_front();
            act = (e.inst == 0)
                ? {running_a, tl_a, tens_a, ones_a, warning_a, expired_a, pulse_a}
                : {running_b, tl_b, tens_b, ones_b, warning_b, expired_b, pulse_b};
            n_checks++;
            if (e.c != cyc) begin
                n_fail++;
                $display("FAIL late_snapshot inst%0d cyc%0d got cycle %0d", e.inst, e.c, cyc);
            end else if (act !== e.snap) begin
                n_fail++;
                $display("FAIL snap inst%0d cyc%0d {run,tl,tens,ones,warn,exp,pulse} got %b_%0d_%0d_%0d_%b%b%b expected %b_%0d_%0d_%0d_%b%b%b",
                         e.inst, cyc,
                         act[18], act[17:11], act[10:7], act[6:3], act[2], act[1], act[0],
                         e.snap[18], e.snap[17:11], e.snap[10:7], e.snap[6:3],
                         e.snap[2], e.snap[1], e.snap[0]);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        start_a = 1'b0;
        pause_a = 1'b0;
        start_b = 1'b0;
        pause_b = 1'b0;

        // Expected timeline, sorted by cycle: (cyc, inst, run, time_left, warn, expired, pulse)
        expect_at( 3, 0, 0,  3, 0, 0, 0);
        expect_at( 3, 1, 0, 12, 0, 0, 0);
        expect_at( 5, 0, 1,  3, 0, 0, 0);
        expect_at( 5, 1, 1, 12, 0, 0, 0);
        expect_at( 8, 0, 1,  3, 0, 0, 0);
        expect_at( 9, 0, 1,  2, 0, 0, 0);
        expect_at( 9, 1, 1, 11, 0, 0, 0);
        expect_at(12, 0, 1,  2, 0, 0, 0);
        expect_at(12, 1, 1, 11, 0, 0, 0);
        expect_at(13, 0, 1,  1, 1, 0, 0);
        expect_at(13, 1, 1, 10, 1, 0, 0);
        expect_at(17, 0, 0,  0, 0, 1, 1);
        expect_at(17, 1, 1,  9, 1, 0, 0);
        expect_at(18, 0, 0,  0, 0, 1, 0);
        expect_at(19, 0, 1,  3, 0, 0, 0);
        expect_at(23, 0, 1,  2, 0, 0, 0);
        expect_at(27, 0, 1,  2, 0, 0, 0);
        expect_at(31, 0, 1,  2, 0, 0, 0);
        expect_at(34, 0, 1,  2, 0, 0, 0);
        expect_at(35, 0, 1,  1, 1, 0, 0);
        expect_at(38, 0, 1,  1, 1, 0, 0);
        expect_at(39, 0, 0,  0, 0, 1, 1);
        expect_at(40, 0, 0,  0, 0, 1, 0);
        expect_at(42, 0, 1,  3, 0, 0, 0);
        expect_at(49, 1, 1,  1, 1, 0, 0);
        expect_at(50, 0, 1,  1, 1, 0, 0);
        expect_at(53, 1, 0,  0, 0, 1, 1);
        expect_at(54, 0, 0,  0, 0, 1, 1);
        expect_at(54, 1, 0,  0, 0, 1, 0);
        expect_at(55, 0, 1,  3, 0, 0, 0);
        expect_at(59, 0, 1,  2, 0, 0, 0);
        expect_at(61, 0, 1,  2, 0, 0, 0);
        expect_at(62, 0, 0,  3, 0, 0, 0);
        expect_at(62, 1, 0, 12, 0, 0, 0);
        expect_at(64, 0, 0,  3, 0, 0, 0);
        expect_at(64, 1, 0, 12, 0, 0, 0);
        expect_at(66, 0, 0,  3, 0, 0, 0);
        expect_at(66, 1, 0, 12, 0, 0, 0);

        at_neg(2);  reset = 1'b1;

        // Start both at edge 5.
        at_neg(4);  start_a = 1'b1; start_b = 1'b1;
        at_neg(5);  start_a = 1'b0; start_b = 1'b0;

        // Start during RUNNING at edge 11 is ignored.
        at_neg(10); start_a = 1'b1;
        at_neg(11); start_a = 1'b0;

        // Restart two cycles after expiry, at edge 19.
        at_neg(18); start_a = 1'b1;
        at_neg(19); start_a = 1'b0;

        // Pause sampled high on edges 24..31.
        at_neg(23); pause_a = 1'b1;
        at_neg(31); pause_a = 1'b0;

        // Restart at edge 42.
        at_neg(41); start_a = 1'b1;
        at_neg(42); start_a = 1'b0;

        // Start held across the final tick (edge 54) and the next edge (55).
        at_neg(53); start_a = 1'b1;
        at_neg(55); start_a = 1'b0;

        // Asynchronous reset 2 time units after edge 62.
        at_neg(61);
        @(posedge clock);
        #2 reset = 1'b0;
        at_neg(64); reset = 1'b1;

        at_neg(70);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
